// File: rtl/tgmux_bbm_ctrl.sv
// tgmux_bbm_ctrl
// Break-before-make select sequencer for the two-input transmission-gate mux.
// Two level requesters are arbitrated round-robin. Only one path conducts at a
// time, and a programmable dead time with both gates off separates hand-overs.
// All gate controls are registered and decoded from the state.
//
// Optional feature: define TGMUX_DWELL_EN to enforce a minimum ON time of
// DWELL_CYC cycles per grant. When it is undefined, release follows the
// request exactly.
module tgmux_bbm_ctrl #(
    parameter int DEAD_CYC  = 2,
    parameter int DWELL_CYC = 4,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req1,
    input  logic req2,
    output logic gnt1,
    output logic gnt2,
    output logic ckn1,
    output logic ckp1,
    output logic ckn2,
    output logic ckp2,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON1  = 2'd1,
        ON2  = 2'd2,
        DEAD = 2'd3
    } state_t;

    localparam int DEAD_EFF  = (DEAD_CYC  < 1) ? 1 : DEAD_CYC;
    localparam int DWELL_EFF = (DWELL_CYC < 1) ? 1 : DWELL_CYC;

    // The counter starts at 0 on entry to a state, so the final cycle of a
    // phase is the one where cnt equals the phase length minus one.
    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_EFF - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef TGMUX_DWELL_EN
    localparam bit DWELL_EN = 1'b1;
`else
    localparam bit DWELL_EN = 1'b0;
`endif

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             prefer2;
    logic             prefer2_next;
    logic             pick1;
    logic             pick2;
    logic             dwell_hold;
    logic             hold1;
    logic             hold2;

    // Arbitration helpers: saturating count, round-robin pick, and ON hold condition
    always_comb begin
        cnt_inc    = (cnt == CNT_MAX) ? cnt : (cnt + CNT_ONE);
        pick1      = req1 & (~req2 | ~prefer2);
        pick2      = req2 & ~pick1;
        dwell_hold = DWELL_EN & (cnt < DWELL_LAST);
        hold1      = req1 | dwell_hold;
        hold2      = req2 | dwell_hold;
    end

    // Next-state logic. Entering ON clears the counter and hands priority to the other path
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        prefer2_next = prefer2;
        case (state)
            IDLE: begin
                if (pick1) begin
                    state_next   = ON1;
                    cnt_next     = '0;
                    prefer2_next = 1'b1;
                end else if (pick2) begin
                    state_next   = ON2;
                    cnt_next     = '0;
                    prefer2_next = 1'b0;
                end
            end
            ON1: begin
                if (hold1) begin
                    cnt_next = cnt_inc;
                end else begin
                    state_next = DEAD;
                    cnt_next   = '0;
                end
            end
            ON2: begin
                if (hold2) begin
                    cnt_next = cnt_inc;
                end else begin
                    state_next = DEAD;
                    cnt_next   = '0;
                end
            end
            DEAD: begin
                if (cnt >= DEAD_LAST) begin
                    cnt_next = '0;
                    if (pick1) begin
                        state_next   = ON1;
                        prefer2_next = 1'b1;
                    end else if (pick2) begin
                        state_next   = ON2;
                        prefer2_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State register with outputs decoded from the next state, so the gates change on the deciding edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            prefer2 <= 1'b0;
            gnt1    <= 1'b0;
            gnt2    <= 1'b0;
            ckn1    <= 1'b0;
            ckp1    <= 1'b1;
            ckn2    <= 1'b0;
            ckp2    <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            prefer2 <= prefer2_next;
            gnt1    <= (state_next == ON1);
            gnt2    <= (state_next == ON2);
            ckn1    <= (state_next == ON1);
            ckp1    <= (state_next != ON1);
            ckn2    <= (state_next == ON2);
            ckp2    <= (state_next != ON2);
            busy    <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_tgmux_bbm_ctrl.sv
// tb_tgmux_bbm_ctrl
// Self-checking bench for tgmux_bbm_ctrl. Two instances share the stimulus:
// dut0 uses a dead time of 2 and dut1 uses a dead time of 0, which clamps to 1.
// Honors TGMUX_DWELL_EN when it is defined for the build.
module tb_tgmux_bbm_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic req1;
    logic req2;
    logic gnt1 [2];
    logic gnt2 [2];
    logic ckn1 [2];
    logic ckp1 [2];
    logic ckn2 [2];
    logic ckp2 [2];
    logic busy [2];

    int checks = 0;
    int fails  = 0;
    bit invEn  = 1'b0;

`ifdef TGMUX_DWELL_EN
    localparam bit DWELL_ON = 1'b1;
`else
    localparam bit DWELL_ON = 1'b0;
`endif
    localparam int DWELL = 4;

    // Free-running clock
    always #5 clk = ~clk;

    tgmux_bbm_ctrl #(.DEAD_CYC(2), .DWELL_CYC(DWELL), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .req1(req1), .req2(req2),
        .gnt1(gnt1[0]), .gnt2(gnt2[0]), .ckn1(ckn1[0]), .ckp1(ckp1[0]),
        .ckn2(ckn2[0]), .ckp2(ckp2[0]), .busy(busy[0])
    );

    tgmux_bbm_ctrl #(.DEAD_CYC(0), .DWELL_CYC(DWELL), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .req1(req1), .req2(req2),
        .gnt1(gnt1[1]), .gnt2(gnt2[1]), .ckn1(ckn1[1]), .ckp1(ckp1[1]),
        .ckn2(ckn2[1]), .ckp2(ckp2[1]), .busy(busy[1])
    );

    // Reference model: who owns the mux, dead cycles still to run, cycles held, whose turn on a tie
    int mOwner   [2];
    int mDeadLeft[2];
    int mHeld    [2];
    int mTurn    [2];

    function automatic int deadEff(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic modelStep(input int d, input logic r, input logic a, input logic b);
        logic own;
        int   pick;
        if (r) begin
            mOwner[d]    = 0;
            mDeadLeft[d] = 0;
            mHeld[d]     = 0;
            mTurn[d]     = 1;
        end else if (mOwner[d] != 0) begin
            own = (mOwner[d] == 1) ? a : b;
            if (own || (DWELL_ON && mHeld[d] < DWELL)) begin
                mHeld[d]++;
            end else begin
                mOwner[d]    = 0;
                mDeadLeft[d] = deadEff(d);
            end
        end else if (mDeadLeft[d] > 1) begin
            mDeadLeft[d]--;
        end else begin
            mDeadLeft[d] = 0;
            if (a && b)  pick = mTurn[d];
            else if (a)  pick = 1;
            else if (b)  pick = 2;
            else         pick = 0;
            if (pick != 0) begin
                mOwner[d] = pick;
                mHeld[d]  = 1;
                mTurn[d]  = 3 - pick;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then compare on the falling edge
    task automatic applyStimulus(input logic r, input logic a, input logic b);
        rst  = r;
        req1 = a;
        req2 = b;
        @(posedge clk);
        for (int d = 0; d < 2; d++) modelStep(d, r, a, b);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("model_gnt1_d%0d", d), int'(gnt1[d]), int'(mOwner[d] == 1));
            checkOutput($sformatf("model_gnt2_d%0d", d), int'(gnt2[d]), int'(mOwner[d] == 2));
            checkOutput($sformatf("model_busy_d%0d", d), int'(busy[d]),
                        int'(mOwner[d] != 0 || mDeadLeft[d] > 0));
        end
    endtask

    // Per-cycle invariants, including the break-before-make gap ahead of every ON entry
    logic prevOn  [2] = '{1'b0, 1'b0};
    logic prevBusy[2] = '{1'b0, 1'b0};
    int   offRun  [2] = '{0, 0};
    always @(negedge clk) begin
        if (invEn) begin
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("mutex_d%0d", d), int'(ckn1[d] & ckn2[d]), 0);
                checkOutput($sformatf("ckp1_compl_d%0d", d), int'(ckp1[d] ^ ckn1[d]), 1);
                checkOutput($sformatf("ckp2_compl_d%0d", d), int'(ckp2[d] ^ ckn2[d]), 1);
                checkOutput($sformatf("gnt_vs_ckn_d%0d", d),
                            int'({gnt1[d], gnt2[d]} ^ {ckn1[d], ckn2[d]}), 0);
                if ((ckn1[d] | ckn2[d]) && !prevOn[d]) begin
                    checkOutput($sformatf("entry_gap_d%0d", d),
                                int'(!prevBusy[d] || offRun[d] >= deadEff(d)), 1);
                end
                if (ckn1[d] | ckn2[d]) offRun[d] = 0;
                else                   offRun[d]++;
                prevOn[d]   = ckn1[d] | ckn2[d];
                prevBusy[d] = busy[d];
            end
        end
    end

    typedef struct {
        logic r;
        logic a;
        logic b;
        logic g1;
        logic g2;
        logic bz;
    } vec_t;

    vec_t tbl[$];

    task automatic addVec(input logic r, input logic a, input logic b,
                          input logic g1, input logic g2, input logic bz);
        vec_t v;
        v.r = r; v.a = a; v.b = b; v.g1 = g1; v.g2 = g2; v.bz = bz;
        tbl.push_back(v);
    endtask

    // Main test sequence
    initial begin
        int offCnt[2];
        bit seen[2];
        int onCnt;
        int busyCnt;
        int grants1;
        int grants2;
        logic a;
        logic b;
        logic pg1;
        logic pg2;

        rst  = 1'b1;
        req1 = 1'b0;
        req2 = 1'b0;

        // Hand-over, no preemption, round-robin ties, reset mid-grant (dut0, dead time 2)
        addVec(1,1,1, 0,0,0);
        addVec(0,1,0, 1,0,1); addVec(0,1,0, 1,0,1);
        addVec(0,1,1, 1,0,1); addVec(0,1,1, 1,0,1);
        addVec(0,0,1, 0,0,1); addVec(0,0,1, 0,0,1);
        addVec(0,0,1, 0,1,1); addVec(0,0,1, 0,1,1); addVec(0,0,1, 0,1,1);
        addVec(0,1,1, 0,1,1);
        addVec(0,1,0, 0,0,1); addVec(0,1,0, 0,0,1);
        addVec(0,1,1, 1,0,1); addVec(0,1,1, 1,0,1); addVec(0,1,1, 1,0,1); addVec(0,1,1, 1,0,1);
        addVec(0,0,1, 0,0,1); addVec(0,1,1, 0,0,1);
        addVec(0,1,1, 0,1,1); addVec(0,1,1, 0,1,1); addVec(0,1,1, 0,1,1); addVec(0,1,1, 0,1,1);
        addVec(0,1,0, 0,0,1); addVec(0,1,0, 0,0,1);
        addVec(0,1,0, 1,0,1); addVec(0,1,0, 1,0,1); addVec(0,1,0, 1,0,1);
        addVec(1,1,0, 0,0,0);
        addVec(0,1,0, 1,0,1); addVec(0,1,0, 1,0,1); addVec(0,1,0, 1,0,1); addVec(0,1,0, 1,0,1);
        addVec(0,0,0, 0,0,1); addVec(0,0,0, 0,0,1);
        addVec(0,0,0, 0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].r, tbl[i].a, tbl[i].b);
            invEn = 1'b1;
            checkOutput($sformatf("vec%0d_gnt1", i), int'(gnt1[0]), int'(tbl[i].g1));
            checkOutput($sformatf("vec%0d_gnt2", i), int'(gnt2[0]), int'(tbl[i].g2));
            checkOutput($sformatf("vec%0d_busy", i), int'(busy[0]), int'(tbl[i].bz));
            checkOutput($sformatf("vec%0d_ckp1", i), int'(ckp1[0]), int'(!tbl[i].g1));
        end

        // Dead-time length on a 1->2 hand-over: 2 cycles for dut0, clamped to 1 for dut1
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        offCnt = '{0, 0};
        seen   = '{1'b0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            for (int d = 0; d < 2; d++) begin
                if (!seen[d]) begin
                    if (gnt2[d]) seen[d] = 1'b1;
                    else         offCnt[d]++;
                end
            end
        end
        checkOutput("dead_len_d0", offCnt[0], 2);
        checkOutput("dead_len_d1", offCnt[1], 1);
        checkOutput("handover_done_d0", int'(seen[0]), 1);
        checkOutput("handover_done_d1", int'(seen[1]), 1);

        // One-cycle pulse on req2: grant lasts the dwell time only when dwell is enabled
        applyStimulus(1'b1, 1'b0, 1'b0);
        onCnt   = 0;
        busyCnt = 0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        if (gnt2[0]) onCnt++;
        if (busy[0]) busyCnt++;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (gnt2[0]) onCnt++;
            if (busy[0]) busyCnt++;
        end
        checkOutput("pulse_on_cycles", onCnt, DWELL_ON ? DWELL : 1);
        checkOutput("pulse_busy_cycles", busyCnt, (DWELL_ON ? DWELL : 1) + 2);
        checkOutput("pulse_back_to_idle", int'(busy[0]), 0);

        // Random requests against the model, with occasional resets
        applyStimulus(1'b1, 1'b0, 1'b0);
        a = 1'b0;
        b = 1'b0;
        grants1 = 0;
        grants2 = 0;
        pg1 = 1'b0;
        pg2 = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 5) == 0) a = ~a;
            if ($urandom_range(0, 5) == 0) b = ~b;
            applyStimulus(($urandom_range(0, 499) == 0), a, b);
            if (gnt1[0] && !pg1) grants1++;
            if (gnt2[0] && !pg2) grants2++;
            pg1 = gnt1[0];
            pg2 = gnt2[0];
        end
        checkOutput("random_path1_served", int'(grants1 > 0), 1);
        checkOutput("random_path2_served", int'(grants2 > 0), 1);

        invEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
